// File: rtl/l_class_oc_echoindicationqueue.sv
// Echo indication queue: buffers heard(meth, v) indications in a small FIFO
// and hands them to the host-side consumer through a scheduler-gated drain rule.
module l_class_oc_echoindicationqueue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              heard__ENA,
  input  logic [DATA_W-1:0] heard_meth,
  input  logic [DATA_W-1:0] heard_v,
  output logic              heard__RDY,
  output logic              deliver__ENA,
  output logic [DATA_W-1:0] deliver_meth,
  output logic [DATA_W-1:0] deliver_v,
  input  logic              deliver__RDY,
  input  logic              rule_enable,
  output logic              rule_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic [31:0]       delivered_count
);

  localparam logic [ADDR_W:0]   OccFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   OccOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [2*DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic [31:0]       count_q, count_d;

  logic enq, deq;
  logic [2*DATA_W-1:0] head;

  // Handshakes and head-of-queue view; everything is forced to its idle value
  // while RST is held so nothing leaks out of the un-reset state.
  always_comb begin
    heard__RDY   = RST || (occ_q != OccFull);
    rule_ready   = !RST && (occ_q != '0) && deliver__RDY;
    deliver__ENA = rule_enable && rule_ready;
    enq          = !RST && heard__ENA && (occ_q != OccFull);
    deq          = deliver__ENA;
    head         = mem[rd_ptr_q];
    if (RST || (occ_q == '0)) begin
      deliver_meth = '0;
      deliver_v    = '0;
    end else begin
      deliver_meth = head[2*DATA_W-1:DATA_W];
      deliver_v    = head[DATA_W-1:0];
    end
    occupancy       = RST ? '0 : occ_q;
    delivered_count = RST ? '0 : count_q;
  end

  // Next-state for pointers, occupancy and the delivery counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PtrOne;
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      count_d  = count_q + 32'd1;
    end
    unique case ({enq, deq})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents survive reset, only the pointers are cleared.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr_q] <= {heard_meth, heard_v};
  end

endmodule

// File: tb/tb_l_class_oc_echoindicationqueue.sv
// Scoreboard bench for the echo indication queue: the stimulus side keeps an
// abstract FIFO model and pushes expected deliveries; a negedge monitor pops
// and compares whenever the DUT fires a delivery.
module tb_l_class_oc_echoindicationqueue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              heard__ENA;
  logic [DATA_W-1:0] heard_meth;
  logic [DATA_W-1:0] heard_v;
  logic              heard__RDY;
  logic              deliver__ENA;
  logic [DATA_W-1:0] deliver_meth;
  logic [DATA_W-1:0] deliver_v;
  logic              deliver__RDY;
  logic              rule_enable;
  logic              rule_ready;
  logic [2:0]        occupancy;
  logic [31:0]       delivered_count;

  l_class_oc_echoindicationqueue #(
    .DEPTH (DEPTH),
    .ADDR_W(2),
    .DATA_W(DATA_W)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .heard__ENA     (heard__ENA),
    .heard_meth     (heard_meth),
    .heard_v        (heard_v),
    .heard__RDY     (heard__RDY),
    .deliver__ENA   (deliver__ENA),
    .deliver_meth   (deliver_meth),
    .deliver_v      (deliver_v),
    .deliver__RDY   (deliver__RDY),
    .rule_enable    (rule_enable),
    .rule_ready     (rule_ready),
    .occupancy      (occupancy),
    .delivered_count(delivered_count)
  );

  always #5 CLK = ~CLK;

  // Reference state: number of queued items, deliveries so far, expected order.
  int          m_occ   = 0;
  int unsigned m_count = 0;
  logic [63:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares all outputs against the model, pops on each delivery.
  always @(negedge CLK) begin
    logic       e_rr;
    logic [63:0] e_head;
    e_rr   = !RST && (m_occ != 0) && deliver__RDY;
    e_head = (!RST && m_occ != 0 && exp_q.size() != 0) ? exp_q[0] : 64'd0;
    check("heard__RDY", 64'(heard__RDY), 64'(RST || (m_occ != DEPTH)));
    check("rule_ready", 64'(rule_ready), 64'(e_rr));
    check("deliver__ENA", 64'(deliver__ENA), 64'(e_rr && rule_enable));
    check("occupancy", 64'(occupancy), RST ? 64'd0 : 64'(m_occ));
    check("delivered_count", 64'(delivered_count), RST ? 64'd0 : 64'(m_count));
    if (deliver__ENA) begin
      if (exp_q.size() == 0) begin
        check("delivery_without_entry", {deliver_meth, deliver_v}, 64'd0);
        n_err += ({deliver_meth, deliver_v} == 64'd0) ? 1 : 0;
      end else begin
        check("deliver_data", {deliver_meth, deliver_v}, exp_q.pop_front());
      end
    end else begin
      check("head_data", {deliver_meth, deliver_v}, e_head);
    end
  end

  // Advance one clock with the currently applied inputs and update the model.
  task automatic tick();
    bit enq, deq, rst;
    logic [63:0] d;
    rst = RST;
    enq = !RST && heard__ENA && (m_occ != DEPTH);
    deq = !RST && (m_occ != 0) && deliver__RDY && rule_enable;
    d   = {heard_meth, heard_v};
    @(posedge CLK);
    if (rst) begin
      m_occ   = 0;
      m_count = 0;
      exp_q.delete();
    end else begin
      if (enq) exp_q.push_back(d);
      m_occ = m_occ + int'(enq) - int'(deq);
      if (deq) m_count++;
    end
    #1;
  endtask

  task automatic drive(input bit ena, input logic [31:0] meth, input logic [31:0] v,
                       input bit drdy, input bit ren);
    heard__ENA   = ena;
    heard_meth   = meth;
    heard_v      = v;
    deliver__RDY = drdy;
    rule_enable  = ren;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    heard__ENA = 1'b1; heard_meth = 32'h55; heard_v = 32'h66;
    deliver__RDY = 1'b1; rule_enable = 1'b1;
    // Reset held two cycles with an enqueue request present.
    tick();
    tick();
    RST = 1'b0;
    drive(0, 0, 0, 0, 0);
    // Two entries then back-to-back delivery.
    drive(1, 32'd1, 32'hA, 0, 0);
    drive(1, 32'd2, 32'hB, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    check("count_after_two", 64'(delivered_count), 64'd2);
    // Fill, overflow attempt, drain.
    for (int i = 0; i < 5; i++) drive(1, 32'(16 + i), 32'(32'h100 + i), 0, 1);
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_rdy", 64'(heard__RDY), 64'd0);
    // Full: enqueue blocked even while a delivery fires.
    drive(1, 32'hDEAD, 32'hBEEF, 1, 1);
    check("occ_after_blocked", 64'(occupancy), 64'd3);
    drive(1, 32'h77, 32'h88, 0, 0);
    check("occ_after_retry", 64'(occupancy), 64'd4);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1);
    // Streaming at occupancy 1 wraps the pointers.
    drive(1, 32'h200, 32'h300, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(32'h201 + i), 32'(32'h301 + i), 1, 1);
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    drive(0, 0, 0, 1, 1);
    // Reset with three stale entries; none may come out afterwards.
    for (int i = 0; i < 3; i++) drive(1, 32'(32'h400 + i), 32'(32'h500 + i), 0, 0);
    RST = 1'b1;
    drive(1, 32'h999, 32'h999, 1, 1);
    RST = 1'b0;
    drive(0, 0, 0, 1, 1);
    check("occ_after_reset", 64'(occupancy), 64'd0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      drive(bit'($urandom_range(0, 2) != 0), $urandom, $urandom,
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 3) != 0));
    end
    RST = 1'b0;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 1);
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
